// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-side and register-port signals of alu_op_sequencer.
// The slave modport is the sequencer; master is whoever drives commands and the ALU result.
interface alu_op_sequencer_if #(
    parameter int OPW = 4
);
    logic           start;
    logic [2:0]     rs;
    logic [2:0]     rt;
    logic [2:0]     rd;
    logic [OPW-1:0] op;
    logic [31:0]    alu_a;
    logic [31:0]    alu_b;
    logic [OPW-1:0] alu_op;
    logic [31:0]    alu_result;
    logic           busy;
    logic           done;
    logic           ld_en;
    logic [2:0]     ld_addr;
    logic [31:0]    ld_data;
    logic [2:0]     dbg_addr;
    logic [31:0]    dbg_data;

    modport master (
        output start, rs, rt, rd, op, alu_result, ld_en, ld_addr, ld_data, dbg_addr,
        input  alu_a, alu_b, alu_op, busy, done, dbg_data
    );

    modport slave (
        input  start, rs, rt, rd, op, alu_result, ld_en, ld_addr, ld_data, dbg_addr,
        output alu_a, alu_b, alu_op, busy, done, dbg_data
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Operand-fetch / writeback controller around an external ALU with an 8 x 32 register bank.
// R0 is hard-wired to zero; loads are accepted only while idle and lose to start.
module alu_op_sequencer #(
    parameter int ALU_LAT = 1,
    parameter int OPW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu_op_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    state_t         state_q;
    logic [31:0]    regs_q [8];
    logic [2:0]     rs_q;
    logic [2:0]     rt_q;
    logic [2:0]     rd_q;
    logic [OPW-1:0] op_q;
    logic [3:0]     cnt_q;
    logic [31:0]    alu_a_q;
    logic [31:0]    alu_b_q;
    logic [OPW-1:0] alu_op_q;
    logic           busy_q;
    logic           done_q;

    function automatic logic [31:0] rd_reg(input logic [2:0] addr);
        return (addr == 3'd0) ? 32'd0 : regs_q[addr];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            for (int unsigned i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        rs_q    <= bus.rs;
                        rt_q    <= bus.rt;
                        rd_q    <= bus.rd;
                        op_q    <= bus.op;
                        busy_q  <= 1'b1;
                        state_q <= FETCH;
                    end else if (bus.ld_en && bus.ld_addr != 3'd0) begin
                        regs_q[bus.ld_addr] <= bus.ld_data;
                    end
                end
                FETCH: begin
                    alu_a_q  <= rd_reg(rs_q);
                    alu_b_q  <= rd_reg(rt_q);
                    alu_op_q <= op_q;
                    cnt_q    <= CNT_INIT;
                    state_q  <= EXEC;
                end
                EXEC: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (rd_q != 3'd0) begin
                            regs_q[rd_q] <= bus.alu_result;
                        end
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.alu_a  = alu_a_q;
    assign bus.alu_b  = alu_b_q;
    assign bus.alu_op = alu_op_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

    always_comb begin
        bus.dbg_data = rd_reg(bus.dbg_addr);
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one instance with ALU_LAT=1, one with ALU_LAT=4,
// each fed by a stub ALU (op 0 = a+b, op 1 = popcount(a)) whose result lags by ALU_LAT cycles.
module tb_alu_op_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_op_sequencer_if #(.OPW(4)) b1 ();
    alu_op_sequencer_if #(.OPW(4)) b4 ();

    alu_op_sequencer #(.ALU_LAT(1), .OPW(4)) u1 (.clk(clk), .rst(rst), .bus(b1));
    alu_op_sequencer #(.ALU_LAT(4), .OPW(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return 32'($countones(a));
            default: return 32'd0;
        endcase
    endfunction

    assign b1.alu_result = alu_f(b1.alu_a, b1.alu_b, b1.alu_op);

    logic [31:0] p1, p2, p3;
    always @(posedge clk) begin
        p1 <= alu_f(b4.alu_a, b4.alu_b, b4.alu_op);
        p2 <= p1;
        p3 <= p2;
    end
    assign b4.alu_result = p3;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic dbg1(input string tag, input logic [2:0] a, input logic [31:0] exp);
        b1.dbg_addr = a;
        #1;
        check(tag, b1.dbg_data, exp);
    endtask

    task automatic dbg4(input string tag, input logic [2:0] a, input logic [31:0] exp);
        b4.dbg_addr = a;
        #1;
        check(tag, b4.dbg_data, exp);
    endtask

    initial begin
        b1.start = 0; b1.rs = 0; b1.rt = 0; b1.rd = 0; b1.op = 0;
        b1.ld_en = 0; b1.ld_addr = 0; b1.ld_data = 0; b1.dbg_addr = 0;
        b4.start = 0; b4.rs = 0; b4.rt = 0; b4.rd = 0; b4.op = 0;
        b4.ld_en = 0; b4.ld_addr = 0; b4.ld_data = 0; b4.dbg_addr = 0;

        // reset state
        rst = 1;
        tick(); tick();
        rst = 0;
        tick();
        for (int i = 0; i < 8; i++) dbg1("rst_dbg", 3'(i), 32'd0);
        check("rst_busy", {31'd0, b1.busy}, 32'd0);
        check("rst_done", {31'd0, b1.done}, 32'd0);

        // reset in the middle of EXEC discards the command
        b4.ld_en = 1; b4.ld_addr = 3'd2; b4.ld_data = 32'h0000_00FF;
        tick();
        b4.ld_en = 0;
        b4.start = 1; b4.rs = 3'd2; b4.rt = 3'd0; b4.rd = 3'd5; b4.op = 4'd1;
        tick();
        b4.start = 0;
        tick(); tick();
        check("midexec_busy_before", {31'd0, b4.busy}, 32'd1);
        rst = 1;
        #1;
        check("midexec_busy", {31'd0, b4.busy}, 32'd0);
        check("midexec_done", {31'd0, b4.done}, 32'd0);
        tick(); tick(); tick(); tick();
        rst = 0;
        tick();
        for (int i = 0; i < 8; i++) dbg4("midexec_dbg", 3'(i), 32'd0);

        // loads and popcount, ALU_LAT=1
        b1.ld_en = 1; b1.ld_addr = 3'd1; b1.ld_data = 32'hF0F0_0001;
        tick();
        b1.ld_addr = 3'd2; b1.ld_data = 32'h0000_00FF;
        tick();
        b1.ld_en = 0;
        dbg1("ld_r1", 3'd1, 32'hF0F0_0001);
        dbg1("ld_r2", 3'd2, 32'h0000_00FF);
        b1.start = 1; b1.rs = 3'd1; b1.rt = 3'd2; b1.rd = 3'd3; b1.op = 4'd1;
        tick();
        b1.start = 0; b1.rs = 3'd6; b1.rt = 3'd7; b1.rd = 3'd6; b1.op = 4'd0;
        check("pc_busy", {31'd0, b1.busy}, 32'd1);
        check("pc_done_early", {31'd0, b1.done}, 32'd0);
        tick();
        check("pc_alu_a", b1.alu_a, 32'hF0F0_0001);
        check("pc_alu_b", b1.alu_b, 32'h0000_00FF);
        check("pc_alu_op", {28'd0, b1.alu_op}, 32'd1);
        tick();
        check("pc_done", {31'd0, b1.done}, 32'd1);
        check("pc_busy_off", {31'd0, b1.busy}, 32'd0);
        dbg1("pc_r3", 3'd3, 32'h0000_0009);
        dbg1("pc_r6_untouched", 3'd6, 32'd0);
        tick();
        check("pc_done_pulse", {31'd0, b1.done}, 32'd0);

        // destination equals source
        b1.start = 1; b1.rs = 3'd1; b1.rt = 3'd2; b1.rd = 3'd1; b1.op = 4'd0;
        tick();
        b1.start = 0;
        tick();
        check("same_alu_a_old", b1.alu_a, 32'hF0F0_0001);
        tick();
        check("same_done", {31'd0, b1.done}, 32'd1);
        dbg1("same_r1", 3'd1, 32'hF0F0_0100);

        // R0 stays zero for writeback and load
        b1.start = 1; b1.rs = 3'd2; b1.rt = 3'd0; b1.rd = 3'd0; b1.op = 4'd1;
        tick();
        b1.start = 0;
        tick(); tick();
        check("r0_done", {31'd0, b1.done}, 32'd1);
        dbg1("r0_wb", 3'd0, 32'd0);
        b1.ld_en = 1; b1.ld_addr = 3'd0; b1.ld_data = 32'hDEAD_BEEF;
        tick();
        b1.ld_en = 0;
        dbg1("r0_ld", 3'd0, 32'd0);

        // ALU_LAT=4: busy for 5 cycles, writeback exactly at E5
        b4.ld_en = 1; b4.ld_addr = 3'd2; b4.ld_data = 32'h0000_00FF;
        tick();
        b4.ld_en = 0;
        b4.start = 1; b4.rs = 3'd2; b4.rt = 3'd0; b4.rd = 3'd4; b4.op = 4'd1;
        tick();
        b4.start = 0; b4.rd = 3'd7;
        for (int i = 0; i < 4; i++) begin
            check("lat4_busy", {31'd0, b4.busy}, 32'd1);
            check("lat4_done_early", {31'd0, b4.done}, 32'd0);
            dbg4("lat4_r4_early", 3'd4, 32'd0);
            tick();
        end
        check("lat4_busy_last", {31'd0, b4.busy}, 32'd1);
        tick();
        check("lat4_busy_off", {31'd0, b4.busy}, 32'd0);
        check("lat4_done", {31'd0, b4.done}, 32'd1);
        dbg4("lat4_r4", 3'd4, 32'h0000_0008);
        dbg4("lat4_r7", 3'd7, 32'd0);
        tick();
        check("lat4_done_pulse", {31'd0, b4.done}, 32'd0);
        dbg4("lat4_r4_late", 3'd4, 32'h0000_0008);

        // back-to-back with start held and loads pending
        b1.start = 1; b1.rs = 3'd1; b1.rt = 3'd2; b1.rd = 3'd1; b1.op = 4'd0;
        b1.ld_en = 1; b1.ld_addr = 3'd6; b1.ld_data = 32'h1234_5678;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("b2b_done", {31'd0, b1.done}, (i % 3 == 2) ? 32'd1 : 32'd0);
            check("b2b_busy", {31'd0, b1.busy}, (i % 3 == 2) ? 32'd0 : 32'd1);
        end
        b1.start = 0; b1.ld_en = 0;
        tick();
        check("b2b_idle", {31'd0, b1.busy}, 32'd0);
        dbg1("b2b_r1", 3'd1, 32'hF0F0_03FD);
        dbg1("b2b_ld_dropped", 3'd6, 32'd0);

        // start pulses while busy are ignored
        b1.start = 1; b1.rs = 3'd1; b1.rt = 3'd2; b1.rd = 3'd7; b1.op = 4'd0;
        tick();
        b1.rd = 3'd5;
        tick();
        b1.start = 0;
        tick();
        check("ign_done", {31'd0, b1.done}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ign_no_done", {31'd0, b1.done}, 32'd0);
            check("ign_no_busy", {31'd0, b1.busy}, 32'd0);
        end
        dbg1("ign_r7", 3'd7, 32'hF0F0_04FC);
        dbg1("ign_r5", 3'd5, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multicycle operand-fetch / writeback controller with an internal 8 x 32-bit register bank.
- Sits directly upstream and downstream of the combinational ALU, including the population-count (HAM) operation.
- On a start command it reads two source registers, drives them plus an opcode to the external ALU, waits ALU_LAT cycles, and writes the ALU result into the destination register.
- Also has a load port for register initialisation and a combinational debug read port.

Parameters:
- ALU_LAT, 1, cycles the ALU result needs after operands are presented; legal range 1..15.
- OPW, 4, width of the ALU opcode field.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  command request; sampled only in IDLE.
- rs  input  3  source register A address.
- rt  input  3  source register B address.
- rd  input  3  destination register address.
- op  input  OPW  ALU opcode, passed through to the ALU.
- alu_a  output  32  registered operand A to the ALU.
- alu_b  output  32  registered operand B to the ALU.
- alu_op  output  OPW  registered opcode to the ALU.
- alu_result  input  32  ALU result; bits beyond the op's natural width arrive already zero.
- busy  output  1  high from command acceptance until writeback.
- done  output  1  one-cycle pulse following writeback.
- ld_en  input  1  load-port write enable.
- ld_addr  input  3  load-port register address.
- ld_data  input  32  load-port write data.
- dbg_addr  input  3  debug read address.
- dbg_data  output  32  combinational read of reg[dbg_addr].

Behaviour:
- Reset (async, any state, including mid-command):
  - all 8 registers, alu_a, alu_b, alu_op, the latched command fields and the latency counter go to 0;
  - busy=0, done=0, state=IDLE;
  - an in-flight command is discarded with no write.
- R0 reads as 0 on every read path. Writes to R0 from writeback or the load port are discarded.
- States: IDLE, FETCH, EXEC.
- IDLE:
  - If start=1 at edge E0: latch rs/rt/rd/op, busy<=1, go to FETCH.
  - Else, if ld_en=1: reg[ld_addr]<=ld_data.
  - If start and ld_en are both high, start wins and the load is dropped.
- FETCH, edge E1:
  - alu_a<=reg[rs_l], alu_b<=reg[rt_l], alu_op<=op_l;
  - cnt<=ALU_LAT-1;
  - go to EXEC.
- EXEC:
  - Each edge with cnt!=0: cnt<=cnt-1.
  - At the edge with cnt==0 (E1+ALU_LAT): reg[rd_l]<=alu_result, done<=1, busy<=0, go to IDLE.
- done is high for exactly the one cycle after writeback. In that cycle the block is in IDLE, so a new start is accepted (back-to-back throughput: one command per ALU_LAT+2 cycles).
- Latency: start edge to writeback edge = ALU_LAT+1 edges. done is visible the cycle after that edge.
- While busy:
  - start and ld_en are ignored; no queuing.
  - rs/rt/rd/op may change freely; latched copies are used.
- Operands are read at the FETCH edge. A load never coincides with FETCH (loads are ignored while busy).
- Source equals destination (e.g. rs=rd): the old value is used as the operand and the new value is written at writeback.
- alu_a/alu_b/alu_op hold their last values when idle.
- dbg_data reflects a register write on the cycle after the write edge.

Test Plan (bench ALU stub: op 0 = a+b, op 1 = popcount(a), registered ALU_LAT deep):
- Reset, then dbg_addr sweep 0..7 -> all dbg_data=0; busy=0, done=0. Assert rst mid-EXEC -> busy/done drop immediately, dbg shows all 0, no write.
- ld R1=0xF0F0_0001, R2=0x0000_00FF; start rs=1, rt=2, rd=3, op=1, ALU_LAT=1 -> alu_a=0xF0F0_0001 one edge after start; done pulses 3 cycles after start; R3=0x0000_0009.
- op=0, rs=1, rt=2, rd=1 (dest = source) -> R1=0xF0F0_0100; alu_a was the old 0xF0F0_0001.
- rd=0 with op=1, rs=2 -> done pulses, R0 still reads 0. ld R0=0xDEAD_BEEF -> R0 still reads 0.
- ALU_LAT=4: start op=1 on R2 -> busy high for exactly 5 cycles; R4=0x0000_0008 written at edge E5, and neither earlier nor later.
- start held high continuously with ld_en=1 -> commands execute back-to-back with start accepted in the done cycle; all loads dropped. start pulsed while busy -> ignored, exactly one done per accepted command.
